// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Arbitrates and sequences the single-port data memory between
//               the pipeline MEM stage (priority, req/ack) and the debug unit
//               (burst dump, valid/ready word hand-off).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int N_BITS    = 32,
    parameter int CNT_BITS  = 8,
    parameter int ADDR_STEP = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    // MEM-stage requester
    input  logic                i_cpu_req,
    input  logic                i_cpu_we,
    input  logic [N_BITS-1:0]   i_cpu_addr,
    input  logic [N_BITS-1:0]   i_cpu_wdata,
    output logic [N_BITS-1:0]   o_cpu_rdata,
    output logic                o_cpu_ack,
    // Debug burst requester
    input  logic                i_dbg_start,
    input  logic [N_BITS-1:0]   i_dbg_base,
    input  logic [CNT_BITS-1:0] i_dbg_count,
    input  logic                i_dbg_ready,
    output logic [N_BITS-1:0]   o_dbg_data,
    output logic                o_dbg_valid,
    output logic                o_dbg_busy,
    output logic                o_dbg_done,
    // dmem side
    output logic                o_mem_enable,
    output logic                o_write,
    output logic                o_read,
    output logic [N_BITS-1:0]   o_mem_addr,
    output logic [N_BITS-1:0]   o_mem_wdata,
    input  logic [N_BITS-1:0]   i_mem_rdata
);

    localparam logic [1:0] c_CIDLE   = 2'd0;
    localparam logic [1:0] c_CRD_CAP = 2'd1;
    localparam logic [1:0] c_CACK    = 2'd2;

    localparam logic [2:0] c_DIDLE  = 3'd0;
    localparam logic [2:0] c_DISSUE = 3'd1;
    localparam logic [2:0] c_DCAP   = 3'd2;
    localparam logic [2:0] c_DHOLD  = 3'd3;
    localparam logic [2:0] c_DDONE  = 3'd4;

    localparam logic [N_BITS-1:0]   c_ADDR_INC = N_BITS'(ADDR_STEP);
    localparam logic [CNT_BITS-1:0] c_CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] c_CNT_ZERO = '0;

    logic [1:0]          r_cpu_state;
    logic [2:0]          r_dbg_state;
    logic [N_BITS-1:0]   r_cpu_rdata;
    logic [N_BITS-1:0]   r_dbg_addr;
    logic [N_BITS-1:0]   r_dbg_data;
    logic [N_BITS-1:0]   r_mem_addr;
    logic [N_BITS-1:0]   r_mem_wdata;
    logic [CNT_BITS-1:0] r_dbg_rem;
    logic                r_dbg_valid;

    logic                w_cpu_issue;
    logic                w_dbg_issue;
    logic                w_issue;
    logic [N_BITS-1:0]   w_mem_addr;
    logic [N_BITS-1:0]   w_mem_wdata;

    // Issue decisions are combinational so dmem sees the request in the same
    // cycle it is granted. Reset gating keeps the enable low while a requester
    // holds req across an asynchronous reset.
    assign w_cpu_issue = !i_reset && (r_cpu_state == c_CIDLE) && i_cpu_req;
    assign w_dbg_issue = !i_reset && (r_dbg_state == c_DISSUE) &&
                         (r_cpu_state == c_CIDLE) && !i_cpu_req;
    assign w_issue     = w_cpu_issue || w_dbg_issue;

    // Outside the issue cycle the bus holds the last driven address/data.
    assign w_mem_addr  = w_cpu_issue ? i_cpu_addr  :
                         w_dbg_issue ? r_dbg_addr  : r_mem_addr;
    assign w_mem_wdata = w_cpu_issue ? i_cpu_wdata : r_mem_wdata;

    assign o_mem_enable = w_issue;
    assign o_write      = w_cpu_issue && i_cpu_we;
    assign o_read       = w_dbg_issue || (w_cpu_issue && !i_cpu_we);
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_wdata  = w_mem_wdata;

    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_ack    = (r_cpu_state == c_CACK);
    assign o_dbg_data   = r_dbg_data;
    assign o_dbg_valid  = r_dbg_valid;
    assign o_dbg_busy   = (r_dbg_state != c_DIDLE);
    assign o_dbg_done   = (r_dbg_state == c_DDONE);

    // Remember the last issued address/data so the bus is stable between issues.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_issue) begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    // CPU sequencer: write acks the cycle after issue, read captures then acks.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_state <= c_CIDLE;
            r_cpu_rdata <= '0;
        end else begin
            case (r_cpu_state)
                c_CIDLE: begin
                    if (w_cpu_issue) begin
                        r_cpu_state <= i_cpu_we ? c_CACK : c_CRD_CAP;
                    end
                end
                c_CRD_CAP: begin
                    r_cpu_rdata <= i_mem_rdata;
                    r_cpu_state <= c_CACK;
                end
                c_CACK:  r_cpu_state <= c_CIDLE;
                default: r_cpu_state <= c_CIDLE;
            endcase
        end
    end

    // Debug burst sequencer: one read per word, each word held until accepted.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_dbg_state <= c_DIDLE;
            r_dbg_addr  <= '0;
            r_dbg_rem   <= '0;
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else begin
            case (r_dbg_state)
                c_DIDLE: begin
                    if (i_dbg_start) begin
                        r_dbg_addr  <= i_dbg_base;
                        r_dbg_rem   <= i_dbg_count;
                        r_dbg_state <= (i_dbg_count == c_CNT_ZERO) ? c_DDONE : c_DISSUE;
                    end
                end
                c_DISSUE: begin
                    if (w_dbg_issue) begin
                        r_dbg_state <= c_DCAP;
                    end
                end
                c_DCAP: begin
                    r_dbg_data  <= i_mem_rdata;
                    r_dbg_valid <= 1'b1;
                    r_dbg_state <= c_DHOLD;
                end
                c_DHOLD: begin
                    if (r_dbg_valid && i_dbg_ready) begin
                        r_dbg_valid <= 1'b0;
                        r_dbg_addr  <= r_dbg_addr + c_ADDR_INC;
                        r_dbg_rem   <= r_dbg_rem - c_CNT_ONE;
                        r_dbg_state <= (r_dbg_rem == c_CNT_ONE) ? c_DDONE : c_DISSUE;
                    end
                end
                c_DDONE: r_dbg_state <= c_DIDLE;
                default: r_dbg_state <= c_DIDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl with a behavioural
//               dmem, a shadow-memory reference and a negedge bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cpu_req, i_cpu_we;
    logic [31:0] i_cpu_addr, i_cpu_wdata;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_ack;
    logic        i_dbg_start, i_dbg_ready;
    logic [31:0] i_dbg_base;
    logic [7:0]  i_dbg_count;
    logic [31:0] o_dbg_data;
    logic        o_dbg_valid, o_dbg_busy, o_dbg_done;
    logic        o_mem_enable, o_write, o_read;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.N_BITS(32), .CNT_BITS(8), .ADDR_STEP(1)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack),
        .i_dbg_start(i_dbg_start), .i_dbg_base(i_dbg_base), .i_dbg_count(i_dbg_count),
        .i_dbg_ready(i_dbg_ready), .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid),
        .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done),
        .o_mem_enable(o_mem_enable), .o_write(o_write), .o_read(o_read),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    // Behavioural dmem: write commits at the issue edge, read data next cycle.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] mem_rdata = 32'h0;
    assign i_mem_rdata = mem_rdata;
    always @(posedge clk) begin
        if (o_mem_enable && o_write) mem[o_mem_addr[7:0]] <= o_mem_wdata;
        if (o_mem_enable && o_read)  mem_rdata <= mem[o_mem_addr[7:0]];
    end

    // Reference: what memory should hold, from the bench's own writes.
    logic [31:0] shadow [256];
    logic [31:0] last_rd;

    int n_cmp = 0;
    int n_fail = 0;
    int cpu_rd_cnt = 0;

    // Bus monitor counters (updated on the sampling edge).
    int rd_cnt = 0, en_cnt = 0, done_cnt = 0, ack_cnt = 0;
    int proto_viol = 0, stab_viol = 0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0, prev_data = 32'h0;
    logic        prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [31:0] dbg_q [$];

    always @(negedge clk) begin
        if (o_mem_enable) en_cnt <= en_cnt + 1;
        if (o_mem_enable && o_read) rd_cnt <= rd_cnt + 1;
        if (o_dbg_done) done_cnt <= done_cnt + 1;
        if (o_cpu_ack) ack_cnt <= ack_cnt + 1;
        if (o_dbg_valid && i_dbg_ready) dbg_q.push_back(o_dbg_data);
        if ((o_mem_enable && (o_write == o_read)) ||
            (!o_mem_enable && (o_write || o_read)) ||
            (!o_mem_enable && !rst && ((o_mem_addr != prev_addr) || (o_mem_wdata != prev_wdata))))
            proto_viol <= proto_viol + 1;
        if (prev_vld && !prev_rdy && !rst && (!o_dbg_valid || (o_dbg_data != prev_data)))
            stab_viol <= stab_viol + 1;
        prev_addr  <= o_mem_addr;
        prev_wdata <= o_mem_wdata;
        prev_vld   <= o_dbg_valid;
        prev_rdy   <= i_dbg_ready;
        prev_data  <= o_dbg_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cpu_rdata"}, o_cpu_rdata, 32'h0);
        chk({tag, "_cpu_ack"},   32'(o_cpu_ack), 32'h0);
        chk({tag, "_dbg_data"},  o_dbg_data, 32'h0);
        chk({tag, "_dbg_valid"}, 32'(o_dbg_valid), 32'h0);
        chk({tag, "_dbg_busy"},  32'(o_dbg_busy), 32'h0);
        chk({tag, "_dbg_done"},  32'(o_dbg_done), 32'h0);
        chk({tag, "_mem_en"},    32'(o_mem_enable), 32'h0);
        chk({tag, "_write"},     32'(o_write), 32'h0);
        chk({tag, "_read"},      32'(o_read), 32'h0);
        chk({tag, "_mem_addr"},  o_mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
    endtask

    // One MEM-stage access; must be issued in its first cycle (CPU has priority).
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input int exp_lat, input string tag);
        int iss = -1, ack = -1, cyc = 0;
        logic [31:0] rd = 32'h0;
        i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = addr; i_cpu_wdata = wdata;
        while (ack < 0 && cyc < 30) begin
            @(negedge clk);
            if (o_mem_enable && iss < 0) begin
                iss = cyc;
                chk({tag, "_iss_write"}, 32'(o_write), 32'(we));
                chk({tag, "_iss_read"},  32'(o_read),  32'(!we));
                chk({tag, "_iss_addr"},  o_mem_addr, addr);
                if (we) chk({tag, "_iss_wdata"}, o_mem_wdata, wdata);
                else    cpu_rd_cnt++;
            end
            if (o_cpu_ack) begin
                ack = cyc;
                rd  = o_cpu_rdata;
            end
            tick();
            cyc++;
        end
        i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = $urandom; i_cpu_wdata = $urandom;
        if (we) shadow[addr[7:0]] = wdata;
        chk({tag, "_ack_seen"}, 32'(ack >= 0), 32'h1);
        chk({tag, "_iss_cycle"}, 32'(iss), 32'h0);
        chk({tag, "_latency"}, 32'(ack - iss), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    task automatic start_burst(input logic [31:0] base, input logic [7:0] cnt);
        i_dbg_start = 1'b1; i_dbg_base = base; i_dbg_count = cnt;
        tick();
        i_dbg_start = 1'b0; i_dbg_base = $urandom; i_dbg_count = 8'($urandom);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        int cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            if (o_dbg_done) seen = 1'b1;
            else begin tick(); cyc++; end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'h1);
        if (seen) begin
            chk({tag, "_busy_at_done"}, 32'(o_dbg_busy), 32'h1);
            @(negedge clk);
            chk({tag, "_busy_after"}, 32'(o_dbg_busy), 32'h0);
            chk({tag, "_done_1cyc"},  32'(o_dbg_done), 32'h0);
        end
        tick();
    endtask

    task automatic burst_check(input logic [31:0] base, input int cnt, input int r0,
                               input int c0, input int d0, input string tag);
        logic [31:0] a;
        chk({tag, "_nwords"}, 32'(dbg_q.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            a = base + 32'(i);
            if (i < dbg_q.size()) chk($sformatf("%s_word%0d", tag, i), dbg_q[i], shadow[a[7:0]]);
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'h1);
        chk({tag, "_dbg_reads"}, 32'((rd_cnt - r0) - (cpu_rd_cnt - c0)), 32'(cnt));
    endtask

    task automatic burst_run(input logic [31:0] base, input logic [7:0] cnt, input string tag);
        int r0 = rd_cnt, c0 = cpu_rd_cnt, d0 = done_cnt;
        dbg_q.delete();
        start_burst(base, cnt);
        wait_done(tag);
        burst_check(base, int'(cnt), r0, c0, d0, tag);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, c0, d0, e0, a0, cyc;
        bit seen, stop;
        logic [31:0] addr, exp;
        logic we;

        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        last_rd = 32'h0;
        tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0000_000A, 32'h0000_0000, 1};
        tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_000A, 2};
        tbl[2]  = '{1'b1, 32'h0000_0004, 32'h0000_0011, 32'h0000_000A, 1};
        tbl[3]  = '{1'b1, 32'h0000_0005, 32'h0000_0022, 32'h0000_000A, 1};
        tbl[4]  = '{1'b1, 32'h0000_0006, 32'h0000_0033, 32'h0000_000A, 1};
        tbl[5]  = '{1'b1, 32'h0000_0007, 32'h0000_0044, 32'h0000_000A, 1};
        tbl[6]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_0033, 2};
        tbl[7]  = '{1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0033, 1};
        tbl[8]  = '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 2};
        tbl[9]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0011, 2};
        tbl[10] = '{1'b0, 32'h0000_0001, 32'h0,         32'h0000_0000, 2};
        tbl[11] = '{1'b1, 32'h0000_0001, 32'h0000_5A5A, 32'h0000_0000, 1};

        rst = 1'b1; i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 32'h0; i_cpu_wdata = 32'h0;
        i_dbg_start = 1'b0; i_dbg_base = 32'h0; i_dbg_count = 8'h0; i_dbg_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Table-driven CPU accesses (also preloads words 4..7).
        for (int i = 0; i < 12; i++) begin
            cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_lat,
                       $sformatf("tbl%0d", i));
        end
        last_rd = 32'h0;

        // Burst dump with ready tied high.
        burst_run(32'h4, 8'd4, "burst");

        // Backpressure on the second word.
        r0 = rd_cnt; c0 = cpu_rd_cnt; d0 = done_cnt;
        dbg_q.delete();
        start_burst(32'h4, 8'd4);
        cyc = 0;
        while (dbg_q.size() < 1 && cyc < 100) begin tick(); cyc++; end
        i_dbg_ready = 1'b0;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (o_dbg_valid) seen = 1'b1;
            else begin tick(); cyc++; end
        end
        chk("bp_word2_seen", 32'(seen), 32'h1);
        chk("bp_word2_data", o_dbg_data, 32'h22);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), 32'(o_dbg_valid), 32'h1);
            chk($sformatf("bp_data_%0d", k), o_dbg_data, 32'h22);
        end
        tick();
        i_dbg_ready = 1'b1;
        wait_done("bp");
        burst_check(32'h4, 4, r0, c0, d0, "bp");

        // Simultaneous start and CPU read: CPU first, burst intact.
        fork
            burst_run(32'h4, 8'd4, "prio_burst");
            cpu_access(1'b0, 32'h5, 32'h0, 32'h22, 2, "prio_cpu");
        join
        last_rd = 32'h22;

        // count = 0: no dmem access, done the next cycle.
        e0 = en_cnt; d0 = done_cnt;
        i_dbg_start = 1'b1; i_dbg_base = 32'h64; i_dbg_count = 8'd0;
        @(negedge clk);
        chk("cnt0_busy_s0", 32'(o_dbg_busy), 32'h0);
        tick();
        i_dbg_start = 1'b0;
        @(negedge clk);
        chk("cnt0_done_s1", 32'(o_dbg_done), 32'h1);
        chk("cnt0_busy_s1", 32'(o_dbg_busy), 32'h1);
        tick();
        @(negedge clk);
        chk("cnt0_done_s2", 32'(o_dbg_done), 32'h0);
        chk("cnt0_busy_s2", 32'(o_dbg_busy), 32'h0);
        tick();
        chk("cnt0_no_enable", 32'(en_cnt - e0), 32'h0);
        chk("cnt0_done_pulses", 32'(done_cnt - d0), 32'h1);

        // Address wrap across 2^32.
        burst_run(32'hFFFF_FFFE, 8'd4, "wrap");

        // Reset after the second word of a burst.
        dbg_q.delete();
        start_burst(32'h4, 8'd4);
        cyc = 0;
        while (dbg_q.size() < 2 && cyc < 200) begin tick(); cyc++; end
        chk("rstb_two_words", 32'(dbg_q.size()), 32'h2);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check_zero("rstb");
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rstb_no_done", 32'(done_cnt - d0), 32'h0);
        chk("rstb_busy_idle", 32'(o_dbg_busy), 32'h0);

        // Reset in the CPU read capture cycle.
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h6;
        @(negedge clk);
        chk("rstc_issue_read", 32'(o_mem_enable && o_read), 32'h1);
        tick();
        a0 = ack_cnt;
        rst = 1'b1;
        #1;
        check_zero("rstc");
        i_cpu_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("rstc_no_ack", 32'(ack_cnt - a0), 32'h0);
        last_rd = 32'h0;

        // A new burst after reset behaves normally.
        burst_run(32'h4, 8'd4, "post_rst");

        // Randomised phase: preload burst region, then concurrent traffic.
        for (int i = 32; i < 48; i++) cpu_access(1'b1, 32'(i), $urandom, last_rd, 1, "pre");
        stop = 1'b0;
        fork
            begin
                fork
                    begin
                        for (int n = 0; n < 40; n++) begin
                            repeat ($urandom_range(0, 3)) tick();
                            we = 1'($urandom_range(0, 1));
                            if (we || ($urandom_range(0, 1) == 0)) addr = 32'($urandom_range(0, 15));
                            else addr = 32'($urandom_range(32, 47));
                            exp = we ? last_rd : shadow[addr[7:0]];
                            cpu_access(we, addr, $urandom, exp, we ? 1 : 2, $sformatf("rnd_cpu%0d", n));
                            if (!we) last_rd = exp;
                        end
                    end
                    begin
                        for (int n = 0; n < 6; n++) begin
                            repeat ($urandom_range(0, 3)) tick();
                            burst_run(32'($urandom_range(32, 40)), 8'($urandom_range(1, 8)),
                                      $sformatf("rnd_burst%0d", n));
                        end
                    end
                join
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    i_dbg_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        i_dbg_ready = 1'b1;
        repeat (2) tick();

        chk("bus_protocol", 32'(proto_viol), 32'h0);
        chk("dbg_stability", 32'(stab_viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
